// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the RV32M issue controller: widths, funct3 codes and
// the controller's state encoding.
package muldiv_issue_ctrl_pkg;

    localparam int MD_XLEN           = 32;
    localparam int MD_TIMEOUT_CYCLES = 48;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_issue_ctrl_cycle_watchdog.sv
// Hang watchdog: down-counter reloaded while idle or cleared, flags the cycle in
// which TIMEOUT_CYCLES consecutive enabled cycles have elapsed.
module muldiv_issue_ctrl_cycle_watchdog #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Terminal count reached on the TIMEOUT_CYCLES-th enabled cycle.
    assign hit = enable & ~clear & (cnt_q == '0);

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue controller for the iterative RV32M mul_div unit: holds operands,
// drives the start/ready handshake, stalls the pipeline and emits the writeback.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int XLEN           = MD_XLEN,
    parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_muldiv,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic [4:0]      ex_rd,
    input  logic            ex_flush,
    output logic            md_start,
    output logic [2:0]      md_opcode,
    output logic [XLEN-1:0] md_rs1,
    output logic [XLEN-1:0] md_rs2,
    input  logic            md_busy,
    input  logic            md_ready,
    input  logic [XLEN-1:0] md_result,
    output logic            stall_req,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            md_timeout
);

    // state    | meaning
    // ST_IDLE  | no op in flight, accepting from EX
    // ST_ISSUE | one-cycle md_start, operands held
    // ST_WAIT  | op running, pipeline stalled until md_ready
    // ST_DRAIN | flushed op still running, its result is discarded

    md_state_e  state_q, state_d;
    logic       accept;
    logic       wd_enable;
    logic       wd_hit;
    logic       wb_fire;
    logic [4:0] rd_q;

    assign accept    = ex_valid & ex_is_muldiv & ~ex_flush & ~md_timeout;
    assign wd_enable = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    muldiv_issue_ctrl_cycle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (md_ready),
        .enable(wd_enable),
        .hit   (wd_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ex_flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (wd_hit || md_ready) state_d = ST_IDLE;
                else if (ex_flush)      state_d = ST_DRAIN;
            end
            ST_DRAIN: if (wd_hit || md_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The pipeline is released in the md_ready cycle so the next op can be
    // accepted in the same cycle the writeback pulse appears.
    always_comb begin
        md_start  = 1'b0;
        stall_req = 1'b0;
        wb_fire   = 1'b0;
        case (state_q)
            ST_IDLE:  stall_req = accept;
            ST_ISSUE: begin
                md_start  = 1'b1;
                stall_req = 1'b1;
            end
            ST_WAIT: begin
                stall_req = ~md_ready & ~ex_flush;
                wb_fire   = md_ready & ~ex_flush & ~wd_hit;
            end
            ST_DRAIN: stall_req = ex_valid & ex_is_muldiv;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_opcode  <= '0;
            md_rs1     <= '0;
            md_rs2     <= '0;
            rd_q       <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            md_timeout <= 1'b0;
        end else begin
            // mul_div re-reads the opcode when it finishes, so these only move on accept.
            if (state_q == ST_IDLE && accept) begin
                md_opcode <= ex_funct3;
                md_rs1    <= ex_rs1_val;
                md_rs2    <= ex_rs2_val;
                rd_q      <= ex_rd;
            end
            wb_valid <= wb_fire;
            if (wb_fire) begin
                wb_rd   <= rd_q;
                wb_data <= md_result;
            end
            if (wd_hit) md_timeout <= 1'b1;
        end
    end

    idle_unit_quiet_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_IDLE && !md_timeout) |-> !md_busy);

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: a behavioural mul_div stand-in plus a
// transaction-timeline reference model, directed scenarios then random traffic.
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    localparam int TMO = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_muldiv, ex_flush;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        md_start;
    logic [2:0]  md_opcode;
    logic [31:0] md_rs1, md_rs2;
    logic        md_busy, md_ready;
    logic [31:0] md_result;
    logic        stall_req, wb_valid, md_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_flush(ex_flush),
        .md_start(md_start), .md_opcode(md_opcode), .md_rs1(md_rs1), .md_rs2(md_rs2),
        .md_busy(md_busy), .md_ready(md_ready), .md_result(md_result),
        .stall_req(stall_req), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_timeout(md_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %08h, expected %08h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [63:0] u;
        case (f)
            F3_MUL:    return a * b;
            F3_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            F3_MULHSU: begin
                p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return p[63:32];
            end
            F3_MULHU: begin
                u = {32'b0, a} * {32'b0, b};
                return u[63:32];
            end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from md_start to md_ready.
    function automatic int md_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1;
        if (b == 0) return 3;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        return 35;
    endfunction

    // mul_div stand-in
    int          md_cnt = 0;
    bit          md_hang_mode = 1'b0;
    bit          md_hang_busy = 1'b0;
    bit          md_rst_prev = 1'b1;
    logic [31:0] md_res_q = '0;

    // reference model: one op timeline plus expected register contents
    bit          op_act = 1'b0;
    bit          op_tmo = 1'b0;
    int          op_ta = 0, op_tr = 0, op_kill = -1;
    logic [4:0]  op_rd = '0;
    logic [31:0] op_res = '0;
    bit          e_tmo = 1'b0;
    bit          e_stall_last = 1'b0;
    logic [2:0]  e_opc = '0;
    logic [31:0] e_rs1 = '0, e_rs2 = '0, e_wb_data = '0;
    logic [4:0]  e_wb_rd = '0;
    int          e_wb_cyc = -1;

    // observations for directed checks
    int          wb_cyc_q[$];
    logic [31:0] wb_dat_q[$];
    int          start_cnt = 0, start_cyc_last = -1, tmo_cyc = -1, stall_hi_cnt = 0;

    task automatic step(input bit r, input bit v, input bit m, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input bit fl);
        bit free, acc, e_stall, e_start, e_wbv;
        @(negedge clk);
        rst = r; ex_valid = v; ex_is_muldiv = m; ex_funct3 = f;
        ex_rs1_val = a; ex_rs2_val = b; ex_rd = d; ex_flush = fl;

        if (md_rst_prev) begin
            md_cnt = 0; md_hang_busy = 1'b0; md_ready = 1'b0; md_result = '0;
        end else begin
            md_ready = 1'b0;
            if (md_cnt > 0) begin
                md_cnt--;
                if (md_cnt == 0) md_ready = 1'b1;
            end
            md_result = md_ready ? md_res_q : $urandom();
            if (md_start && !r) begin
                md_res_q = rv32m(md_opcode, md_rs1, md_rs2);
                if (md_hang_mode) md_hang_busy = 1'b1;
                else md_cnt = md_lat(md_opcode, md_rs1, md_rs2);
            end
        end
        md_busy = (md_cnt > 0) || md_hang_busy;
        md_rst_prev = r;

        #1;
        free = !op_act || cyc > op_tr;
        acc  = v && m && !fl && !e_tmo;
        if (free)                             e_stall = acc;
        else if (cyc == op_ta + 1)            e_stall = 1'b1;
        else if (op_kill >= 0 && op_kill < cyc) e_stall = v && m;
        else                                  e_stall = !(cyc == op_tr && !op_tmo) && !fl;
        e_start = op_act && (cyc == op_ta + 1);
        e_wbv   = (cyc == e_wb_cyc);

        if (chk_en) begin
            chk("wb_valid",   32'(wb_valid),   32'(e_wbv));
            chk("wb_rd",      32'(wb_rd),      32'(e_wb_rd));
            chk("wb_data",    wb_data,         e_wb_data);
            chk("md_start",   32'(md_start),   32'(e_start));
            chk("md_opcode",  32'(md_opcode),  32'(e_opc));
            chk("md_rs1",     md_rs1,          e_rs1);
            chk("md_rs2",     md_rs2,          e_rs2);
            chk("stall_req",  32'(stall_req),  32'(e_stall));
            chk("md_timeout", 32'(md_timeout), 32'(e_tmo));
        end
        if (wb_valid) begin wb_cyc_q.push_back(cyc); wb_dat_q.push_back(wb_data); end
        if (md_start) begin start_cnt++; start_cyc_last = cyc; end
        if (md_timeout && tmo_cyc < 0) tmo_cyc = cyc;
        if (stall_req) stall_hi_cnt++;

        if (r) begin
            op_act = 1'b0; e_tmo = 1'b0; e_opc = '0; e_rs1 = '0; e_rs2 = '0;
            e_wb_rd = '0; e_wb_data = '0; e_wb_cyc = -1;
        end else begin
            if (free && acc) begin
                op_act = 1'b1; op_ta = cyc; op_kill = -1; op_tmo = md_hang_mode;
                op_tr  = cyc + 1 + (op_tmo ? TMO : md_lat(f, a, b));
                op_rd  = d; op_res = rv32m(f, a, b);
                e_opc  = f; e_rs1 = a; e_rs2 = b;
            end else if (!free && fl && op_kill < 0) begin
                op_kill = cyc;
            end
            if (op_act && cyc == op_tr) begin
                if (op_tmo) e_tmo = 1'b1;
                else if (op_kill < 0) begin
                    e_wb_cyc = cyc + 1; e_wb_rd = op_rd; e_wb_data = op_res;
                end
            end
        end
        e_stall_last = e_stall;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Present an op and keep it in EX while the pipeline is held.
    task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, output int t);
        int n = 0;
        t = cyc;
        step(1'b0, 1'b1, 1'b1, f, a, b, d, 1'b0);
        while (e_stall_last && n < 200) begin
            step(1'b0, 1'b1, 1'b1, f, a, b, d, 1'b0);
            n++;
        end
        chk("issue_bound", 32'(n < 200), 32'd1);
    endtask

    task automatic clear_obs();
        wb_cyc_q.delete(); wb_dat_q.delete();
        start_cnt = 0; start_cyc_last = -1; tmo_cyc = -1; stall_hi_cnt = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int t, t2;
        bit v, m, fl, r;
        logic [2:0] f;
        logic [31:0] a, b;
        logic [4:0] d;
        rst = 1'b1; ex_valid = 0; ex_is_muldiv = 0; ex_funct3 = 0; ex_rs1_val = 0;
        ex_rs2_val = 0; ex_rd = 0; ex_flush = 0; md_busy = 0; md_ready = 0; md_result = 0;

        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        idle(2);

        clear_obs();
        issue_op(F3_MUL, 32'd7, 32'd6, 5'd5, t);
        idle(3);
        chk("t1_wb_count", 32'(wb_cyc_q.size()), 32'd1);
        if (wb_cyc_q.size() > 0) begin
            chk("t1_wb_latency", 32'(wb_cyc_q[0] - t), 32'd3);
            chk("t1_wb_data", wb_dat_q[0], 32'd42);
        end
        chk("t1_start_count", 32'(start_cnt), 32'd1);
        chk("t1_start_cycle", 32'(start_cyc_last - t), 32'd1);
        chk("t1_stall_cycles", 32'(stall_hi_cnt), 32'd2);

        clear_obs();
        issue_op(F3_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, t);
        idle(3);
        chk("t2_wb_count", 32'(wb_cyc_q.size()), 32'd1);
        if (wb_cyc_q.size() > 0) begin
            chk("t2_wb_latency", 32'(wb_cyc_q[0] - t), 32'd37);
            chk("t2_wb_data", wb_dat_q[0], 32'hFFFF_FFFA);
        end
        chk("t2_stall_cycles", 32'(stall_hi_cnt), 32'd36);

        clear_obs();
        issue_op(F3_DIVU, 32'h1234, 32'h0, 5'd10, t);
        idle(3);
        chk("t3_divz_count", 32'(wb_cyc_q.size()), 32'd1);
        if (wb_cyc_q.size() > 0) begin
            chk("t3_divz_latency", 32'(wb_cyc_q[0] - t), 32'd5);
            chk("t3_divz_data", wb_dat_q[0], 32'hFFFF_FFFF);
        end
        clear_obs();
        issue_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, t);
        idle(3);
        chk("t3_ovf_count", 32'(wb_cyc_q.size()), 32'd1);
        if (wb_cyc_q.size() > 0) begin
            chk("t3_ovf_latency", 32'(wb_cyc_q[0] - t), 32'd5);
            chk("t3_ovf_data", wb_dat_q[0], 32'h0);
        end

        clear_obs();
        issue_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, t);
        issue_op(F3_MUL, 32'd3, 32'd4, 5'd13, t2);
        idle(3);
        chk("t4_wb_count", 32'(wb_cyc_q.size()), 32'd2);
        if (wb_cyc_q.size() > 1) begin
            chk("t4_first_latency", 32'(wb_cyc_q[0] - t), 32'd3);
            chk("t4_first_data", wb_dat_q[0], 32'hFFFF_FFFE);
            chk("t4_accept_on_wb", 32'(t2), 32'(wb_cyc_q[0]));
            chk("t4_second_latency", 32'(wb_cyc_q[1] - t2), 32'd3);
            chk("t4_second_data", wb_dat_q[1], 32'h0000_000C);
        end

        clear_obs();
        t = cyc;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, F3_DIV, 32'd1000, 32'd7, 5'd14, 1'b0);
        step(1'b0, 1'b1, 1'b1, F3_DIV, 32'd1000, 32'd7, 5'd14, 1'b1);
        issue_op(F3_MUL, 32'd2, 32'd9, 5'd15, t2);
        idle(3);
        chk("t5_wb_count", 32'(wb_cyc_q.size()), 32'd1);
        if (wb_cyc_q.size() > 0) begin
            chk("t5_wb_latency", 32'(wb_cyc_q[0] - t), 32'd40);
            chk("t5_wb_data", wb_dat_q[0], 32'd18);
        end

        clear_obs();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, F3_DIV, 32'd500, 32'd3, 5'd16, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        idle(40);
        chk("t6_rst_wb_count", 32'(wb_cyc_q.size()), 32'd0);
        chk("t6_rst_start_count", 32'(start_cnt), 32'd1);

        clear_obs();
        md_hang_mode = 1'b1;
        issue_op(F3_DIV, 32'd100, 32'd7, 5'd17, t);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, F3_MUL, 32'd5, 32'd5, 5'd18, 1'b0);
        chk("t6_tmo_cycle", 32'(tmo_cyc - t), 32'd50);
        chk("t6_tmo_start_count", 32'(start_cnt), 32'd1);
        chk("t6_tmo_wb_count", 32'(wb_cyc_q.size()), 32'd0);
        md_hang_mode = 1'b0;
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        idle(2);

        v = 0; m = 0; f = 0; a = 0; b = 0; d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!e_stall_last) begin
                v = ($urandom_range(0, 3) != 0);
                m = ($urandom_range(0, 3) != 0);
                f = 3'($urandom_range(0, 7));
                a = pick();
                b = pick();
                d = 5'($urandom_range(0, 31));
            end
            fl = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(r, v, m, f, a, b, d, fl);
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
